// File: rtl/reset_manager_pkg.sv
// Shared definitions for the staged reset manager.
// Holds the FSM state encoding, default timing constants, a small constant
// helper, and the reset-active level macro used by every block in this slice.
`ifndef RM_RST_ACTIVE
`define RM_RST_ACTIVE 1'b0
`endif

package reset_manager_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } rm_state_t;

    localparam int RM_SYNC_STAGES = 2;
    localparam int RM_LOCK_STABLE = 1024;
    localparam int RM_HOLD_CYCLES = 16;
    localparam int RM_STAGGER     = 8;
    localparam int RM_DEBOUNCE    = 65536;

    function automatic int rm_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every flop
//   d     : asynchronous input
//   q     : synchronized output, STAGES clocks after d
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == `RM_RST_ACTIVE) chain <= '0;
        else                         chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_manager.sv
// Staged system reset generator.
// Waits for a continuously stable PLL lock, holds both resets, releases the
// peripheral reset first and the CPU reset STAGGER cycles later. Lock loss
// or a debounced button press puts the system back into reset.
//   clk            : system clock from the clock manager
//   reset          : asynchronous active-low master reset
//   locked         : PLL lock status (asynchronous)
//   btn            : raw push-button, active-high (asynchronous, bouncy)
//   periph_reset_n : peripheral/bus reset, active-low
//   cpu_reset_n    : CPU core reset, active-low
//   ready          : system fully out of reset
//   lock_lost      : sticky, set when lock drops while running
module reset_manager
    import reset_manager_pkg::*;
#(
    parameter int SYNC_STAGES = RM_SYNC_STAGES,
    parameter int LOCK_STABLE = RM_LOCK_STABLE,
    parameter int HOLD_CYCLES = RM_HOLD_CYCLES,
    parameter int STAGGER     = RM_STAGGER,
    parameter int DEBOUNCE    = RM_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic locked,
    input  logic btn,
    output logic periph_reset_n,
    output logic cpu_reset_n,
    output logic ready,
    output logic lock_lost
);

    localparam int CW = $clog2(rm_max3(LOCK_STABLE, HOLD_CYCLES, STAGGER) + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic          locked_s, btn_s;
    logic          btn_db, btn_db_q, press;
    logic [DW-1:0] dcnt;
    logic [CW-1:0] cnt;
    rm_state_t     state, nxt;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (.clk(clk), .rst_n(reset), .d(locked), .q(locked_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_btn  (.clk(clk), .rst_n(reset), .d(btn),    .q(btn_s));

    // Debouncer: accept a new level only after DEBOUNCE consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == `RM_RST_ACTIVE) begin
            dcnt     <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s != btn_db) begin
                if (dcnt == DW'(DEBOUNCE - 1)) begin
                    btn_db <= btn_s;
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

    // Lock loss overrides everything; a press only restarts from RELEASE/RUN.
    function automatic rm_state_t next_state(input rm_state_t s, input logic ls,
                                             input logic pr, input logic done);
        next_state = s;
        if (s != ST_WAIT_LOCK && !ls) begin
            next_state = ST_WAIT_LOCK;
        end else begin
            case (s)
                ST_WAIT_LOCK: if (ls)   next_state = ST_STABLE;
                ST_STABLE:    if (done) next_state = ST_HOLD;
                ST_HOLD:      if (done) next_state = ST_RELEASE;
                ST_RELEASE:   if (pr)   next_state = ST_HOLD;
                              else if (done) next_state = ST_RUN;
                ST_RUN:       if (pr)   next_state = ST_HOLD;
                default:      next_state = ST_WAIT_LOCK;
            endcase
        end
    endfunction

    // The counter is loaded with N-1 on entry so a state lasts exactly N cycles.
    function automatic logic [CW-1:0] reload(input rm_state_t s);
        case (s)
            ST_STABLE:  reload = CW'(LOCK_STABLE - 1);
            ST_HOLD:    reload = CW'(HOLD_CYCLES - 1);
            ST_RELEASE: reload = CW'(STAGGER - 1);
            default:    reload = '0;
        endcase
    endfunction

    assign nxt = next_state(state, locked_s, press, cnt == '0);

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == `RM_RST_ACTIVE) begin
            state          <= ST_WAIT_LOCK;
            cnt            <= '0;
            periph_reset_n <= 1'b0;
            cpu_reset_n    <= 1'b0;
            ready          <= 1'b0;
            lock_lost      <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)    cnt <= reload(nxt);
            else if (cnt != '0)  cnt <= cnt - 1'b1;
            periph_reset_n <= (nxt == ST_RELEASE) || (nxt == ST_RUN);
            cpu_reset_n    <= (nxt == ST_RUN);
            ready          <= (nxt == ST_RUN);
            if (state == ST_RUN && nxt == ST_WAIT_LOCK) lock_lost <= 1'b1;
        end
    end

endmodule

// File: doc/reset_manager.md
# reset_manager

Generates the processor's staged system resets from the clock manager's `locked` status and a board push-button. It sits directly after the system clock block and runs on its output clock. Internal resets are held until the PLL has been continuously locked for a programmable time. Release is staged: peripheral reset first, CPU reset later. The block re-enters reset on loss of lock or on a debounced button press.

## Interface

Parameters:
- `SYNC_STAGES`, 2, flip-flop depth of each input synchronizer (≥2)
- `LOCK_STABLE`, 1024, cycles `locked` must stay high before the reset sequence starts
- `HOLD_CYCLES`, 16, cycles both resets are held after the stable check or after a button press
- `STAGGER`, 8, cycles between peripheral release and CPU release
- `DEBOUNCE`, 65536, consecutive stable cycles required to accept a button level change

Ports:
- `clk` input 1: system clock from the clock manager
- `reset` input 1: asynchronous, active-low master reset
- `locked` input 1: PLL lock status, asynchronous to `clk`
- `btn` input 1: raw push-button, active-high, bouncy, asynchronous
- `periph_reset_n` output 1: peripheral/bus reset, active-low
- `cpu_reset_n` output 1: CPU core reset, active-low
- `ready` output 1: high when the system is fully out of reset
- `lock_lost` output 1: sticky flag, set when lock drops while in RUN

## Operation

- `locked` and `btn` each pass through a `SYNC_STAGES` synchronizer, producing `locked_s` and `btn_s`.
- Debouncer:
  - A counter increments while `btn_s` differs from the debounced level `btn_db`.
  - Any cycle where `btn_s` equals `btn_db` clears the counter.
  - When the counter reaches `DEBOUNCE`, `btn_db` takes the value of `btn_s` and the counter clears.
  - `press` is a one-cycle pulse on a 0→1 edge of `btn_db`.
- FSM states:
  - WAIT_LOCK: go to STABLE when `locked_s` = 1; the stable counter clears.
  - STABLE: count cycles with `locked_s` high. After `LOCK_STABLE` cycles go to HOLD. If `locked_s` falls, return to WAIT_LOCK.
  - HOLD: after `HOLD_CYCLES` cycles go to RELEASE.
  - RELEASE: after `STAGGER` cycles go to RUN.
  - RUN: terminal until lock loss or a button press.
- Global transitions:
  - From any state other than WAIT_LOCK, `locked_s` = 0 → WAIT_LOCK. This takes priority over everything else.
  - In RELEASE or RUN, `press` → HOLD with the counter cleared.
  - `press` in WAIT_LOCK, STABLE or HOLD is ignored. HOLD is not restarted.
- Output decode:
  - `periph_reset_n` = 1 in RELEASE and RUN.
  - `cpu_reset_n` = 1 and `ready` = 1 in RUN only.
- `lock_lost` is set on a RUN→WAIT_LOCK transition and is cleared only by `reset`.
- Single shared down-counter for STABLE/HOLD/RELEASE, width `$clog2(max(LOCK_STABLE,HOLD_CYCLES,STAGGER)+1)`. Reloaded on each state entry.

## Timing

- `reset` low asynchronously forces:
  - state WAIT_LOCK, all counters 0, `btn_db` = 0, all synchronizer flops 0
  - `periph_reset_n` = 0, `cpu_reset_n` = 0, `ready` = 0, `lock_lost` = 0
- All outputs are registered. They are decoded from the next state, so each output changes on the same edge as its state transition. No glitches.
- Edge numbering: edge 0 is the first rising edge at which `locked` is sampled high. `locked_s` = 1 at edge `SYNC_STAGES`.
  - WAIT_LOCK→STABLE at edge `SYNC_STAGES+1`.
  - `periph_reset_n` rises at edge `SYNC_STAGES+1+LOCK_STABLE+HOLD_CYCLES`.
  - `cpu_reset_n` and `ready` rise `STAGGER` edges later.
- Lock loss: `locked` low sampled at edge k → all outputs low at edge `k+SYNC_STAGES+1`.
- Button: `btn` held from edge 0 with no bounce → `btn_db` = 1 at edge `SYNC_STAGES+DEBOUNCE` → resets low at the next edge.
- Button held indefinitely: exactly one `press`, no retrigger. Release of the button has no effect.
- Simultaneous lock loss and `press`: lock loss wins, and `lock_lost` is set if the FSM was in RUN.

## Structure

- Shared header/package holds:
  - FSM state encodings (WAIT_LOCK, STABLE, HOLD, RELEASE, RUN)
  - default parameter constants
  - the active-low reset level macro used by other blocks
- One sub-module, `sync_ff`, a parameterized `SYNC_STAGES` flop chain with async active-low reset, instantiated twice.
- The debouncer and FSM stay inline.

## Test plan

All scenarios use `SYNC_STAGES`=2, `LOCK_STABLE`=8, `HOLD_CYCLES`=4, `STAGGER`=2, `DEBOUNCE`=4.

- Power-up: `reset` released, `locked` rises at edge 0 → `periph_reset_n` rises at edge 15, `cpu_reset_n` and `ready` rise at edge 17, `lock_lost` stays 0.
- Lock glitch: `locked` low for 1 cycle during STABLE → state returns to WAIT_LOCK, stable count restarts, and `periph_reset_n` rises 15 edges after `locked` returns high.
- Lock loss in RUN: `locked` falls at edge k → all outputs 0 at edge k+3, `lock_lost` = 1. It stays 1 through re-lock and the full sequence until `reset` is asserted.
- Bouncy button in RUN: `btn` toggles every 2 cycles for 20 cycles and then settles low → no reset. A clean press held from edge 0 → resets low at edge 7, `periph_reset_n` high at edge 11, `cpu_reset_n` high at edge 13, with no retrigger while held.
- Simultaneous events: `locked` falls and `press` occurs in the same cycle in RUN → WAIT_LOCK (not HOLD), `lock_lost` = 1.
- Mid-sequence `reset`: assert `reset` during HOLD or RELEASE → all outputs 0 immediately (asynchronously), and the full sequence restarts on release.
